store_merge_unit: RTL
=====================

// Module: store_merge_unit
// PURPOSE
//  Store-side counterpart of the load size/extension path. Takes a store request (addr, 64-bit rs2 data, size)
//  and performs the 64-bit data-memory write. Partial stores (SB/SH/SW) use a read-modify-write of the
//  aligned doubleword. SD writes directly. Sits between the datapath store stage and the data memory.
//  Start/done handshake; the control FSM stalls while busy is high.
// PARAMETERS
//  RD_LAT    1   cycles from mem_rd asserted to mem_rdata valid (1..4)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   request strobe, sampled only when busy=0
//  size       in   3   0=SD, 1=SB, 2=SH, 3=SW, 4..7 illegal
//  addr       in   64  byte address of the store
//  wdata_in   in   64  store data, valid bits right-aligned
//  mem_rdata  in   64  doubleword read from data memory
//  mem_addr   out  64  doubleword-aligned address {addr[63:3],3'b0}
//  mem_rd     out  1   memory read strobe, 1 cycle
//  mem_wr     out  1   memory write strobe, 1 cycle
//  mem_wdata  out  64  merged doubleword to write
//  busy       out  1   request in progress
//  done       out  1   1-cycle completion pulse
//  err        out  1   1-cycle pulse with done: misaligned or illegal size, no write issued
// BEHAVIOUR
//  - Reset: state=IDLE; mem_rd, mem_wr, busy, done, err = 0; mem_addr, mem_wdata = 0.
//  - start with busy=0 latches addr, wdata_in, size. Later changes to those inputs are ignored.
//  - States: IDLE, RD, WAIT, WR, FIN.
//  - IDLE->FIN: illegal size, or misaligned (SH addr[0]!=0; SW addr[1:0]!=0; SD addr[2:0]!=0). err=1 in FIN.
//  - IDLE->WR: SD aligned.
//  - IDLE->RD: SB/SH/SW aligned.
//  - RD: mem_rd=1 for one cycle, then WAIT.
//  - WAIT: count RD_LAT-1 further cycles. On the cycle rdata is valid (RD_LAT cycles after mem_rd),
//    capture mem_rdata, go to WR.
//  - WR: mem_wr=1 for exactly one cycle with mem_wdata=merged, then FIN.
//  - FIN: done=1 (err as decided), busy=0 next cycle, return to IDLE.
//  - busy=1 from the cycle after accepted start through FIN inclusive.
//  - Minimum latency, start to done: SD=2 cycles; partial=3+RD_LAT cycles.
//  - Merge, byte offset o=addr[2:0]:
//    - SB replaces byte o with wdata_in[7:0].
//    - SH replaces bytes o..o+1 with wdata_in[15:0].
//    - SW replaces bytes o..o+3 with wdata_in[31:0].
//    - All other bytes are kept from mem_rdata. SD writes wdata_in unchanged.
//  - No sign/zero extension on stores; upper bits of wdata_in beyond the size are ignored.
//  - start while busy=1 is dropped, not queued. start in the same cycle as done is also dropped.
//    A back-to-back start is accepted in the cycle after done.
//  - mem_addr holds the latched aligned address from accept until the next accept.
//  - Reset mid-operation: next edge is IDLE. A pending mem_wr is suppressed. No done is produced.
//  - mem_rd and mem_wr are never high in the same cycle.
// STRUCTURE
//  - Package store_pkg holds:
//    - typedef enum logic [2:0] st_size_t {ST_SD=0, ST_SB=1, ST_SH=2, ST_SW=3}
//    - state enum smu_state_t
//    - function is_misaligned(size, off)
//  - Sub-module store_lane_merge (combinational): (old64, new64, size, off) -> merged64, built from byte enables.
//  - The FSM and the latency counter stay in store_merge_unit.
// TESTING
//  1. SD addr=0x100, data=0x1122334455667788
//     -> no mem_rd; mem_wr 1 cycle, wdata=0x1122334455667788, mem_addr=0x100; done 2 cycles after start.
//  2. SB addr=0x105, data=0xAB, mem_rdata=0xFFEEDDCCBBAA9988
//     -> mem_wr with 0xFFEEABCCBBAA9988; done, err=0.
//  3. SW addr=0x104, data=0xDEADBEEF, rdata=0x0123456789ABCDEF
//     -> 0xDEADBEEF89ABCDEF. SH at addr=0x106, data=0x1234, same rdata -> 0x1234456789ABCDEF.
//  4. SW addr=0x102 (misaligned), and separately size=5
//     -> no mem_rd/mem_wr; done=err=1 on the same cycle, 1 cycle after start.
//  5. start re-pulsed every cycle during an SB -> exactly one mem_wr and one done. Then a start the cycle
//     after done is accepted. Repeat with RD_LAT=3: done 6 cycles after start.
//  6. reset asserted in WAIT of an SH -> mem_wr never asserted, busy=0 and done=0 after the edge;
//     a following SD completes normally.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types and helpers for the store merge unit.
package store_pkg;

  // Store width encoding as presented by the datapath; codes 4..7 are illegal.
  typedef enum logic [2:0] {
    ST_SD = 3'd0,
    ST_SB = 3'd1,
    ST_SH = 3'd2,
    ST_SW = 3'd3
  } st_size_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_FIN
  } smu_state_t;

  // True when the byte offset does not meet the natural alignment of the size.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      ST_SD:   mis = (off != 3'd0);
      ST_SH:   mis = off[0];
      ST_SW:   mis = (off[1:0] != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Request / data-memory bundle of the store merge unit.
interface store_merge_unit_if;
  logic        start;
  logic [2:0]  size;
  logic [63:0] addr;
  logic [63:0] wdata_in;
  logic [63:0] mem_rdata;
  logic [63:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  // Requester and memory side (drives requests and read data).
  modport master (
    output start, size, addr, wdata_in, mem_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, err
  );

  // The store merge unit itself.
  modport slave (
    input  start, size, addr, wdata_in, mem_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge of store data into an aligned doubleword.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [63:0] old_data,
  input  logic [63:0] new_data,
  input  logic [2:0]  size,
  input  logic [2:0]  off,
  output logic [63:0] merged
);

  logic [7:0]  base_en;
  logic [7:0]  lane_en;
  logic [63:0] shifted;

  // Build byte enables from size/offset and pick each byte from new or old data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    base_en = 8'h00;
    case (size)
      ST_SB:   base_en = 8'h01;
      ST_SH:   base_en = 8'h03;
      ST_SW:   base_en = 8'h0F;
      ST_SD:   base_en = 8'hFF;
      default: base_en = 8'h00;
    endcase
    lane_en = base_en << off;
    shifted = new_data << {off, 3'b000};
    merged  = old_data;
    for (int i = 0; i < 8; i++) begin
      if (lane_en[i]) merged[i*8 +: 8] = shifted[i*8 +: 8];
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store path to data memory: SD written directly, SB/SH/SW via read-modify-write.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  store_merge_unit_if.slave bus
);

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  smu_state_t  state, next_state;
  logic [1:0]  cnt;
  logic [2:0]  size_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic        err_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [63:0] merged;
  logic        accept;
  logic        bad_req;
  logic        rdata_valid;

  assign accept      = (state == S_IDLE) && bus.start;
  assign bad_req     = bus.size[2] || is_misaligned(bus.size, bus.addr[2:0]);
  assign rdata_valid = (state == S_WAIT) && (cnt == LAST_CNT);

  store_lane_merge u_merge (
    .old_data (bus.mem_rdata),
    .new_data (wdata_q),
    .size     (size_q),
    .off      (off_q),
    .merged   (merged)
  );

  // State register, request latch, latency counter and write-data register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      size_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        size_q     <= bus.size;
        off_q      <= bus.addr[2:0];
        wdata_q    <= bus.wdata_in;
        err_q      <= bad_req;
        mem_addr_q <= {bus.addr[63:3], 3'b000};
        if (bus.size == ST_SD) mem_wdata_q <= bus.wdata_in;
      end
      if (state == S_RD) cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 2'd1;
      if (rdata_valid) mem_wdata_q <= merged;
    end
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    next_state = state;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          if (bad_req)                 next_state = S_FIN;
          else if (bus.size == ST_SD)  next_state = S_WR;
          else                         next_state = S_RD;
        end
      end
      S_RD: begin
        bus.mem_rd = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (rdata_valid) next_state = S_WR;
      end
      S_WR: begin
        bus.mem_wr = 1'b1;
        next_state = S_FIN;
      end
      S_FIN: begin
        bus.done   = 1'b1;
        bus.err    = err_q;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
